// File: rtl/spi_master_multimode.sv
// SPI master with run-time CPOL/CPHA, bit order and chip-select selection.
// It drives a start/busy/done handshake, error pulses on rejected starts, and a wrapping transfer count.
module spi_master_multimode #(
  parameter int DATA_W  = 32,
  parameter int CLK_DIV = 5,
  parameter int NUM_CS  = 1,
  parameter int CS_W    = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic              miso,
  output logic              sclk,
  output logic              mosi,
  output logic [NUM_CS-1:0] cs_n,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              err,
  output logic [CNT_W-1:0]  xfer_count
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EDGE_W = $clog2(2 * DATA_W + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W);
  localparam logic [31:0]       NUM_CS_W  = 32'(NUM_CS);

  typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [EDGE_W-1:0]   edge_q, edge_d;
  logic                sclk_q, sclk_d, mosi_q, mosi_d;
  logic [NUM_CS-1:0]   cs_n_q, cs_n_d;
  logic                busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                cpha_q, cpha_d, lsb_q, lsb_d;
  logic [DATA_W-1:0]   tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
  logic [31:0]         cs_sel_w;
  logic [EDGE_W-1:0]   edge_k;
  logic                tick, sample;

  function automatic logic first_bit(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? {1'b0, w[DATA_W-1:1]} : {w[DATA_W-2:0], 1'b0};
  endfunction

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic b,
                                                 input logic lsb);
    return lsb ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
  endfunction

  assign cs_sel_w = 32'(cs_sel);
  assign tick     = (div_q == DIV_LAST);
  assign edge_k   = edge_q + EDGE_W'(1);
  // Odd edges lead; the sampling edge is the leading one only when cpha=0.
  assign sample   = edge_k[0] ^ cpha_q;

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    edge_d    = edge_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    cs_n_d    = cs_n_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    rx_data_d = rx_data_q;
    cnt_d     = cnt_q;
    cpha_d    = cpha_q;
    lsb_d     = lsb_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    if (state_q == IDLE) begin
      if (start) begin
        if (cs_sel_w < NUM_CS_W) begin
          state_d = LEAD;
          div_d   = '0;
          edge_d  = '0;
          busy_d  = 1'b1;
          sclk_d  = cpol;
          cpha_d  = cpha;
          lsb_d   = lsb_first;
          for (int i = 0; i < NUM_CS; i++) cs_n_d[i] = (cs_sel_w != 32'(i));
          if (!cpha) begin
            mosi_d  = first_bit(tx_data, lsb_first);
            tx_sh_d = shift_out(tx_data, lsb_first);
          end else begin
            tx_sh_d = tx_data;
          end
        end else begin
          err_d = 1'b1;
        end
      end
    end else begin
      err_d = start;
      div_d = tick ? '0 : div_q + DIV_W'(1);
      if (tick) begin
        if (state_q == TRAIL) begin
          state_d   = IDLE;
          cs_n_d    = '1;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          mosi_d    = 1'b0;
          rx_data_d = rx_sh_q;
          cnt_d     = cnt_q + CNT_W'(1);
        end else begin
          edge_d  = edge_k;
          sclk_d  = ~sclk_q;
          state_d = (edge_k == EDGE_LAST) ? TRAIL : SHIFT;
          if (sample) begin
            rx_sh_d = shift_in(rx_sh_q, miso, lsb_q);
          end else if (edge_k != EDGE_LAST) begin
            mosi_d  = first_bit(tx_sh_q, lsb_q);
            tx_sh_d = shift_out(tx_sh_q, lsb_q);
          end
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q   <= IDLE;
      div_q     <= '0;
      edge_q    <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= '1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rx_data_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      edge_q    <= edge_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rx_data_q <= rx_data_d;
      cnt_q     <= cnt_d;
    end
    cpha_q  <= cpha_d;
    lsb_q   <= lsb_d;
    tx_sh_q <= tx_sh_d;
    rx_sh_q <= rx_sh_d;
  end

  assign sclk       = sclk_q;
  assign mosi       = mosi_q;
  assign cs_n       = cs_n_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign rx_data    = rx_data_q;
  assign xfer_count = cnt_q;

endmodule

// File: tb/tb_spi_master_multimode.sv
// Directed bench for spi_master_multimode: 8-bit words, divider 2, four chip selects, 2-bit counter.
// A behavioural slave (or a MOSI->MISO loopback) supplies MISO and records the MOSI bits it samples.
module tb_spi_master_multimode;
  localparam int DW = 8, DIV = 2, NCS = 4, CSW = 3, CW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, cpol, cpha, lsb, miso;
  logic [DW-1:0] tx;
  logic [CSW-1:0] sel;
  logic sclk, mosi, busy, done, err;
  logic [NCS-1:0] cs_n;
  logic [DW-1:0] rx;
  logic [CW-1:0] cnt;

  int n_checks = 0, n_errors = 0;

  spi_master_multimode #(.DATA_W(DW), .CLK_DIV(DIV), .NUM_CS(NCS), .CS_W(CSW), .CNT_W(CW)) dut (
    .clk_in(clk), .reset(rst), .start(start), .tx_data(tx), .cs_sel(sel), .cpol(cpol),
    .cpha(cpha), .lsb_first(lsb), .miso(miso), .sclk(sclk), .mosi(mosi), .cs_n(cs_n),
    .busy(busy), .done(done), .rx_data(rx), .err(err), .xfer_count(cnt));

  // Behavioural slave: drives its word on non-sampling edges, records MOSI on sampling edges.
  logic loopback = 1'b1, s_en = 1'b0, s_cpol = 1'b0, s_cpha = 1'b0, s_lsb = 1'b0;
  logic [DW-1:0] s_word = '0, mseq = '0;
  logic s_miso = 1'b0, sclk_prev = 1'b0, cs_prev = 1'b0, cs_act;
  int s_n = 0, s_rxn = 0;

  assign cs_act = (cs_n != '1);
  assign miso   = loopback ? mosi : s_miso;

  function automatic logic sbit(input logic [DW-1:0] w, input logic l, input int n);
    return l ? w[n] : w[DW-1-n];
  endfunction

  always @(negedge clk) begin
    if (s_en) begin
      if (cs_act && !cs_prev) begin
        s_rxn <= 0;
        if (!s_cpha) begin
          s_miso <= sbit(s_word, s_lsb, 0);
          s_n    <= 1;
        end else begin
          s_n <= 0;
        end
      end else if (cs_act && sclk !== sclk_prev) begin
        if ((sclk_prev == s_cpol) != s_cpha) begin
          if (s_rxn < DW) mseq[DW-1-s_rxn] <= mosi;
          s_rxn <= s_rxn + 1;
        end else if (s_n < DW) begin
          s_miso <= sbit(s_word, s_lsb, s_n);
          s_n    <= s_n + 1;
        end
      end
    end
    sclk_prev <= sclk;
    cs_prev   <= cs_act;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic c1_busy, c1_sclk, c1_mosi, c1_err, c_err1, c_err2, r_busy, r_done, r_sclk;
  logic [NCS-1:0] c1_csn, r_csn;
  logic [DW-1:0] r_rx;
  int t_done, t_first, t_edges, exp_cnt;

  task automatic xfer(input logic [DW-1:0] t_tx, input logic [CSW-1:0] t_sel,
                      input logic t_cpol, input logic t_cpha, input logic t_lsb,
                      input int poke, input int rst_at);
    logic prev;
    @(negedge clk);
    tx = t_tx; sel = t_sel; cpol = t_cpol; cpha = t_cpha; lsb = t_lsb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c1_busy = busy; c1_csn = cs_n; c1_sclk = sclk; c1_mosi = mosi; c1_err = err;
    prev = sclk; t_done = -1; t_first = -1; t_edges = 0;
    for (int n = 2; n <= 100 && t_done < 0; n++) begin
      @(negedge clk);
      if (n == poke + 1) begin c_err1 = err; start = 1'b0; end
      if (n == poke + 2) c_err2 = err;
      if (n == rst_at + 1) begin
        r_busy = busy; r_done = done; r_sclk = sclk; r_csn = cs_n; r_rx = rx; rst = 1'b0;
      end
      if (sclk !== prev) begin
        t_edges++;
        if (t_first < 0) t_first = n;
      end
      prev = sclk;
      if (done === 1'b1) t_done = n;
      if (n == poke) begin start = 1'b1; tx = ~t_tx; sel = '0; end
      if (n == rst_at) rst = 1'b1;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int nd, last;
    rst = 1'b1; start = 1'b0; tx = '0; sel = '0; cpol = 1'b0; cpha = 1'b0; lsb = 1'b0;
    exp_cnt = 0;
    pulse_reset();
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 0);
    check("rst_cs_n", cs_n, 4'hF);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_rx", rx, 0);
    check("rst_cnt", cnt, 0);

    // Mode 0, MSB first, loopback
    loopback = 1'b1;
    xfer(8'hA5, 3'd0, 1'b0, 1'b0, 1'b0, -10, -10);
    exp_cnt = (exp_cnt + 1) % 4;
    check("m0_busy1", c1_busy, 1);
    check("m0_csn1", c1_csn, 4'hE);
    check("m0_sclk1", c1_sclk, 0);
    check("m0_mosi1", c1_mosi, 1);
    check("m0_err1", c1_err, 0);
    check("m0_first_edge", t_first, 3);
    check("m0_edges", t_edges, 16);
    check("m0_done_at", t_done, 35);
    check("m0_rx", rx, 8'hA5);
    check("m0_cnt", cnt, exp_cnt);
    @(negedge clk);
    check("m0_done_clr", done, 0);
    check("m0_idle", {busy, mosi, cs_n}, 6'b00_1111);

    // Mode 3, LSB first, slave returns 0xC3
    loopback = 1'b0; s_en = 1'b1; s_cpol = 1'b1; s_cpha = 1'b1; s_lsb = 1'b1; s_word = 8'hC3;
    xfer(8'h3C, 3'd0, 1'b1, 1'b1, 1'b1, -10, -10);
    exp_cnt = (exp_cnt + 1) % 4;
    check("m3_sclk1", c1_sclk, 1);
    check("m3_mosi_seq", mseq, 8'b0011_1100);
    check("m3_rx", rx, 8'hC3);
    check("m3_done_at", t_done, 35);
    check("m3_cnt", cnt, exp_cnt);
    @(negedge clk);
    check("m3_idle_sclk", sclk, 1);

    // Mode 1 and mode 2, MSB first, slave returns 0x5A
    s_cpol = 1'b0; s_cpha = 1'b1; s_lsb = 1'b0; s_word = 8'h5A;
    xfer(8'h96, 3'd0, 1'b0, 1'b1, 1'b0, -10, -10);
    exp_cnt = (exp_cnt + 1) % 4;
    check("m1_rx", rx, 8'h5A);
    check("m1_mosi_seq", mseq, 8'h96);
    check("m1_cnt", cnt, exp_cnt);
    s_cpol = 1'b1; s_cpha = 1'b0;
    xfer(8'h69, 3'd0, 1'b1, 1'b0, 1'b0, -10, -10);
    exp_cnt = (exp_cnt + 1) % 4;
    check("m2_mosi1", c1_mosi, 0);
    check("m2_rx", rx, 8'h5A);
    check("m2_mosi_seq", mseq, 8'h69);
    check("m2_cnt", cnt, exp_cnt);

    // Chip-select decode, out-of-range select, start while busy
    loopback = 1'b1; s_en = 1'b0;
    xfer(8'h81, 3'd2, 1'b0, 1'b0, 1'b0, -10, -10);
    exp_cnt = (exp_cnt + 1) % 4;
    check("cs2_csn", c1_csn, 4'b1011);
    check("cs2_rx", rx, 8'h81);
    check("cs2_cnt", cnt, exp_cnt);
    @(negedge clk);
    sel = 3'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("cs5_err", err, 1);
    check("cs5_csn", cs_n, 4'hF);
    check("cs5_busy", busy, 0);
    @(negedge clk);
    check("cs5_err_clr", err, 0);
    xfer(8'h5B, 3'd1, 1'b0, 1'b0, 1'b0, 6, -10);
    exp_cnt = (exp_cnt + 1) % 4;
    check("busy_err", c_err1, 1);
    check("busy_err_clr", c_err2, 0);
    check("busy_csn", c1_csn, 4'b1101);
    check("busy_done_at", t_done, 35);
    check("busy_rx", rx, 8'h5B);
    check("busy_cnt", cnt, exp_cnt);

    // Reset after edge 7, then a clean transfer
    xfer(8'hF0, 3'd3, 1'b0, 1'b0, 1'b0, -10, 15);
    exp_cnt = 0;
    check("mid_rst_busy", r_busy, 0);
    check("mid_rst_done", r_done, 0);
    check("mid_rst_sclk", r_sclk, 0);
    check("mid_rst_csn", r_csn, 4'hF);
    check("mid_rst_rx", r_rx, 0);
    check("mid_rst_no_done", t_done, -1);
    check("mid_rst_cnt", cnt, exp_cnt);
    xfer(8'hC6, 3'd1, 1'b0, 1'b0, 1'b0, -10, -10);
    exp_cnt = (exp_cnt + 1) % 4;
    check("post_rst_done_at", t_done, 35);
    check("post_rst_rx", rx, 8'hC6);
    check("post_rst_cnt", cnt, exp_cnt);

    // Back-to-back with start held high; counter wraps at 4
    pulse_reset();
    exp_cnt = 0;
    check("b2b_cnt0", cnt, 0);
    @(negedge clk);
    tx = 8'h3A; sel = '0; cpol = 1'b0; cpha = 1'b0; lsb = 1'b0; start = 1'b1;
    nd = 0; last = 0;
    for (int n = 1; n <= 250 && nd < 5; n++) begin
      @(negedge clk);
      if (nd > 0 && n == last + 1) check("b2b_accept", busy, 1);
      if (done === 1'b1) begin
        nd++;
        exp_cnt = (exp_cnt + 1) % 4;
        check("b2b_cnt", cnt, exp_cnt);
        check("b2b_period", n - last, 35);
        check("b2b_rx", rx, 8'h3A);
        last = n;
        if (nd == 5) start = 1'b0;
      end
    end
    start = 1'b0;
    check("b2b_transfers", nd, 5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
